// File: rtl/adc_channel_scanner_pkg.sv
// +----------------------------------------------------------------------+
// | adc_pkg : shared constants and helpers for the ADC channel scanner    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package adc_pkg;

  localparam int SAMPLE_W = 12;
  localparam int CH_W     = 3;
  localparam int CFG_W    = 5;

  localparam int CFG_SD  = 0;
  localparam int CFG_OS  = 1;
  localparam int CFG_S1  = 2;
  localparam int CFG_S0  = 3;
  localparam int CFG_UNI = 4;

  typedef logic [CH_W-1:0]     ch_t;
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [CFG_W-1:0]    cfg_t;

  // Single-ended mux select; the LTC2308 address bits are not in binary order.
  function automatic cfg_t ch_to_cfg(input ch_t n, input logic uni);
    cfg_t c;
    c          = '0;
    c[CFG_SD]  = 1'b1;
    c[CFG_OS]  = n[0];
    c[CFG_S1]  = n[2];
    c[CFG_S0]  = n[1];
    c[CFG_UNI] = uni;
    return c;
  endfunction

  function automatic ch_t lowest_ch(input logic [7:0] mask);
    ch_t r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) r = ch_t'(i);
    end
    return r;
  endfunction

  function automatic ch_t next_ch(input logic [7:0] mask, input ch_t cur);
    ch_t  r;
    logic found;
    r     = lowest_ch(mask);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && (i > int'(cur)) && mask[i]) begin
        r     = ch_t'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_avg_acc.sv
// +----------------------------------------------------------------------+
// | adc_avg_acc : sums 2^AVG_LOG2 samples and emits their truncated mean  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module adc_avg_acc
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    vld,
  input  sample_t data,
  input  logic    clr,
  output logic    res_vld,
  output sample_t res
);

  localparam int SUM_W = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  always_comb begin
    sum   = acc_q + SUM_W'(data);
    last  = (cnt_q == CNT_LAST);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (vld) begin
      // The final sample is folded in combinationally so the mean is ready this cycle.
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign res_vld = vld && !clr && last;
  assign res     = sum[SUM_W-1:AVG_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_channel_scanner.sv
// +----------------------------------------------------------------------+
// | adc_channel_scanner : drives LTC2308 cfg, tags and averages samples   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module adc_channel_scanner
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int UNIPOLAR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [7:0]          ch_mask,
  output logic [CFG_W-1:0]    adc_cfg,
  input  logic [SAMPLE_W-1:0] adc_sample,
  input  logic                adc_sample_vld,
  output logic [SAMPLE_W-1:0] out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam int DW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [DW-1:0] DWELL_LAST  = DW'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]    NUM_CH_MASK = 8'((1 << NUM_CH) - 1);
  localparam logic          UNI_BIT     = (UNIPOLAR != 0);

  logic [0:0]    state_q, state_d;
  ch_t           cur_ch_q, cur_ch_d;
  ch_t           pend_ch_q, pend_ch_d;
  logic          pend_vld_q, pend_vld_d;
  logic [DW-1:0] dwell_q, dwell_d;
  cfg_t          adc_cfg_q, adc_cfg_d;
  sample_t       out_data_q, out_data_d;
  ch_t           out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;

  logic [7:0] mask_lim, eff_mask;
  logic       acc_vld, acc_clr, res_vld, drop;
  sample_t    res;

  assign mask_lim = ch_mask & NUM_CH_MASK;
  assign eff_mask = (mask_lim == 8'h00) ? 8'h01 : mask_lim;

  adc_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk     (clk),
    .rst     (rst),
    .vld     (acc_vld),
    .data    (adc_sample),
    .clr     (acc_clr),
    .res_vld (res_vld),
    .res     (res)
  );

  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    pend_ch_d  = pend_ch_q;
    pend_vld_d = pend_vld_q;
    dwell_d    = dwell_q;
    acc_vld    = 1'b0;
    acc_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cur_ch_d   = lowest_ch(eff_mask);
        pend_vld_d = 1'b0;
        dwell_d    = '0;
        acc_clr    = 1'b1;
        if (enable) state_d = ST_SCAN;
      end
      default: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          cur_ch_d   = lowest_ch(eff_mask);
          pend_vld_d = 1'b0;
          dwell_d    = '0;
          acc_clr    = 1'b1;
        end else if (adc_sample_vld) begin
          // This sample was converted with last frame's cfg, i.e. pend_ch.
          acc_vld    = pend_vld_q;
          pend_ch_d  = cur_ch_q;
          pend_vld_d = 1'b1;
          if (dwell_q == DWELL_LAST) begin
            dwell_d  = '0;
            cur_ch_d = next_ch(eff_mask, cur_ch_q);
          end else begin
            dwell_d  = dwell_q + DW'(1);
          end
        end
      end
    endcase
  end

  assign adc_cfg_d = ch_to_cfg(cur_ch_d, UNI_BIT);

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    drop        = 1'b0;
    if (res_vld) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = res;
        out_ch_d    = pend_ch_q;
        out_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_ch_q    <= '0;
      pend_ch_q   <= '0;
      pend_vld_q  <= 1'b0;
      dwell_q     <= '0;
      adc_cfg_q   <= ch_to_cfg(ch_t'(0), UNI_BIT);
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      pend_ch_q   <= pend_ch_d;
      pend_vld_q  <= pend_vld_d;
      dwell_q     <= dwell_d;
      adc_cfg_q   <= adc_cfg_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign adc_cfg   = adc_cfg_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_channel_scanner.sv
// +----------------------------------------------------------------------+
// | tb_adc_channel_scanner : LTC2308 frame model + averaging scoreboard   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_adc_channel_scanner;

  localparam int AVG_LOG2  = 2;
  localparam int N         = 1 << AVG_LOG2;
  localparam int FRAME     = 80;
  localparam int LATCH_POS = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic [4:0]  adc_cfg;
  logic [11:0] adc_sample = '0;
  logic        adc_sample_vld = 1'b0;
  logic [11:0] out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  adc_channel_scanner #(.NUM_CH(8), .AVG_LOG2(AVG_LOG2), .UNIPOLAR(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .adc_cfg(adc_cfg),
    .adc_sample(adc_sample), .adc_sample_vld(adc_sample_vld), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok, input logic [31:0] act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, not an allowed value", name, act);
    end
  endtask

  function automatic logic [2:0] cfg_to_ch(input logic [4:0] c);
    return {c[2], c[3], c[1]};
  endfunction

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
  } res_t;

  res_t exp_q[$];

  // Driver + reference model state
  int          pos = 0;
  int          frame_no = 0;
  int          phase = 0;
  bit          seq_mode = 1'b0;
  logic [11:0] seq_val = 12'd9;
  logic [4:0]  lat_now = 5'h11, lat_prev = 5'h11, last_cfg = 5'h11;
  logic [2:0]  true_ch, grp_ch;
  int          grp_n = 0, grp_sum = 0;
  bit          grp_mixed = 1'b0;
  bit          discard = 1'b1, hold = 1'b0, ovr_now = 1'b0, ovr_next = 1'b0;
  bit          got, drop, pop;
  bit          v_e = 1'b0, en_e = 1'b0, en_em1 = 1'b0, r_e = 1'b1;
  res_t        res;

  initial begin : driver
    forever begin
      @(posedge clk);
      #2;
      if (adc_cfg !== last_cfg) begin
        checks++;
        if (!(rst || r_e || v_e || !en_e || !en_em1)) begin
          errors++;
          $display("FAIL cfg_timing: adc_cfg moved to %0h, required no change outside the cycle after sample_vld", adc_cfg);
        end
        last_cfg = adc_cfg;
      end
      if (pos == LATCH_POS) lat_now = adc_cfg;

      pos            = (pos + 1) % FRAME;
      adc_sample_vld = (pos == FRAME - 1);
      true_ch        = cfg_to_ch(lat_prev);
      if (!enable) seq_val = 12'd9;
      if (adc_sample_vld) begin
        adc_sample = seq_mode ? seq_val : 12'($urandom_range(0, 4095));
        seq_val    = seq_val + 12'd1;
        lat_prev   = lat_now;
        frame_no++;
      end

      ovr_now = ovr_next;
      got     = 1'b0;
      drop    = 1'b0;
      if (rst) begin
        hold = 1'b0; ovr_next = 1'b0; ovr_now = 1'b0; exp_q.delete();
        discard = 1'b1; grp_n = 0; grp_sum = 0; grp_mixed = 1'b0;
      end else begin
        pop = hold && out_ready;
        if (!enable) begin
          discard = 1'b1; grp_n = 0; grp_sum = 0; grp_mixed = 1'b0;
        end else if (adc_sample_vld) begin
          if (discard) begin
            discard = 1'b0;
          end else begin
            if (grp_n == 0) grp_ch = true_ch;
            else if (true_ch != grp_ch) grp_mixed = 1'b1;
            grp_sum += int'(adc_sample);
            grp_n++;
            if (grp_n == N) begin
              chk_ok("single_channel_average", !grp_mixed, {29'd0, true_ch});
              res.ch   = grp_ch;
              res.data = 12'(grp_sum / N);
              got = 1'b1;
              grp_n = 0; grp_sum = 0; grp_mixed = 1'b0;
            end
          end
        end
        if (got) begin
          if (!hold || out_ready) begin
            exp_q.push_back(res);
            hold = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (pop) begin
          hold = 1'b0;
        end
        if (overrun_clr) ovr_next = 1'b0;
        if (drop)        ovr_next = 1'b1;
      end
      v_e    = adc_sample_vld;
      en_em1 = en_e;
      en_e   = enable;
      r_e    = rst;
    end
  end

  // Monitor: pops the scoreboard on every accepted output
  int          pops_ph[8] = '{default: 0};
  logic [11:0] first_data[8];
  logic [2:0]  first_ch[8];
  bit          seen3 = 1'b0, stall_prev = 1'b0, last_vld = 1'b0;
  logic [11:0] prev_data;
  logic [2:0]  prev_ch, last_ch;
  int          mon_phase = 0;
  res_t        e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      chk("overrun", overrun, ovr_now);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_ch", out_ch, prev_ch);
      end
      if (phase != mon_phase) begin
        mon_phase = phase;
        last_vld  = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_ok("unexpected_output", 1'b0, {20'd0, out_data});
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_ch", out_ch, e.ch);
          if (pops_ph[phase] == 0) begin
            first_data[phase] = out_data;
            first_ch[phase]   = out_ch;
          end
          pops_ph[phase]++;
          case (phase)
            1: chk("mask80_ch", out_ch, 3'd7);
            2, 5, 6: chk_ok("mask05_alternate",
                            (out_ch == 3'd0 || out_ch == 3'd2) && (!last_vld || out_ch != last_ch),
                            {29'd0, out_ch});
            3: chk("mask00_ch", out_ch, 3'd0);
            4: begin
              if (seen3) chk("mask08_ch", out_ch, 3'd3);
              else chk_ok("mask01_08_ch", out_ch == 3'd0 || out_ch == 3'd3, {29'd0, out_ch});
              if (out_ch == 3'd3) seen3 = 1'b1;
            end
            default: ;
          endcase
          last_ch  = out_ch;
          last_vld = 1'b1;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ch    = out_ch;
    end
  end

  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = frame_no + n;
    budget = n * FRAME + 2 * FRAME;
    do begin
      @(posedge clk);
      #1;
      budget--;
    end while (!(frame_no >= target && pos == 20) && budget > 0);
    if (budget <= 0) chk_ok("frame_timeout", 1'b0, frame_no);
  endtask

  // Idle across one cfg latch point so the first kept sample matches the idle cfg
  task automatic restart(input logic [7:0] m);
    enable  = 1'b0;
    ch_mask = m;
    wait_frames(1);
    enable  = 1'b1;
  endtask

  logic [4:0] cfg_tab[8] = '{5'h11, 5'h13, 5'h19, 5'h1B, 5'h15, 5'h17, 5'h1D, 5'h1F};

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    chk("rst_adc_cfg", adc_cfg, 5'h11);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;

    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      ch_mask = 8'(1 << c);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("cfg_ch%0d", c), adc_cfg, cfg_tab[c]);
    end

    seq_mode = 1'b1;
    phase = 1;
    restart(8'h80);
    wait_frames(9);
    chk("mask80_first_data", first_data[1], 12'd11);
    chk("mask80_first_ch", first_ch[1], 3'd7);
    chk("mask80_results", pops_ph[1], 2);
    seq_mode = 1'b0;

    phase = 2;
    restart(8'h05);
    wait_frames(20);
    out_ready = 1'b0;
    wait_frames(12);
    chk("stall_overrun", overrun, 1);
    chk("stall_out_valid", out_valid, 1);
    out_ready   = 1'b1;
    overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    overrun_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);
    wait_frames(8);

    phase = 3;
    restart(8'h00);
    wait_frames(12);
    chk_ok("mask00_results", pops_ph[3] >= 2, pops_ph[3]);

    phase = 4;
    restart(8'h01);
    wait_frames(6);
    ch_mask = 8'h08;
    wait_frames(14);
    chk("mask08_reached", seen3, 1);

    phase = 5;
    restart(8'h05);
    wait_frames(6);
    repeat (20) @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_frames(2);
    phase  = 6;
    enable = 1'b1;
    wait_frames(14);
    chk("post_rst_results", pops_ph[6], 3);

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire
